// File: rtl/pwm_deadtime_pkg.sv
// Shared constants for the complementary PWM dead-time stage.
// State codes are fixed 3-bit values so they stay stable across tools and waveforms.
package pwm_deadtime_pkg;

    localparam int DT_WIDTH_DEF = 16;

    localparam logic [2:0] ST_OFF       = 3'd0;
    localparam logic [2:0] ST_DEAD_TO_H = 3'd1;
    localparam logic [2:0] ST_HIGH      = 3'd2;
    localparam logic [2:0] ST_DEAD_TO_L = 3'd3;
    localparam logic [2:0] ST_LOW       = 3'd4;
    localparam logic [2:0] ST_FAULT     = 3'd5;

endpackage

// File: rtl/pwm_fault_sync.sv
// Multi-flop synchronizer bringing the asynchronous fault request into the clk domain.
module pwm_fault_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pwm_deadtime.sv
// Complementary high/low gate driver with programmable dead time, enable gating
// and a latched fault shutdown for half-bridge drivers.
module pwm_deadtime
    import pwm_deadtime_pkg::*;
#(
    parameter int DT_WIDTH    = DT_WIDTH_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                pwm_in,
    input  logic                enable,
    input  logic [DT_WIDTH-1:0] dead_time,
    input  logic                fault,
    input  logic                fault_clr,
    output logic                pwm_h,
    output logic                pwm_l,
    output logic                dt_active,
    output logic                fault_latched
);

    logic [2:0]          state;
    logic [2:0]          state_next;
    logic [DT_WIDTH-1:0] cnt;
    logic [DT_WIDTH-1:0] cnt_next;
    logic [DT_WIDTH-1:0] dt_load;
    logic                fault_s;

    pwm_fault_sync #(
        .STAGES(SYNC_STAGES)
    ) u_fault_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (fault),
        .q    (fault_s)
    );

    // A zero dead time still yields one cycle with both gates off.
    assign dt_load = (dead_time == '0) ? '0 : dead_time - DT_WIDTH'(1);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (fault_s) begin
            state_next = ST_FAULT;
            cnt_next   = '0;
        end else if (state == ST_FAULT) begin
            if (fault_clr) begin
                state_next = ST_OFF;
            end
        end else if (!enable) begin
            state_next = ST_OFF;
            cnt_next   = '0;
        end else begin
            case (state)
                ST_OFF: begin
                    state_next = pwm_in ? ST_DEAD_TO_H : ST_DEAD_TO_L;
                    cnt_next   = dt_load;
                end
                ST_DEAD_TO_H: begin
                    if (!pwm_in) begin
                        state_next = ST_LOW;
                        cnt_next   = '0;
                    end else if (cnt == '0) begin
                        state_next = ST_HIGH;
                    end else begin
                        cnt_next = cnt - DT_WIDTH'(1);
                    end
                end
                ST_HIGH: begin
                    if (!pwm_in) begin
                        state_next = ST_DEAD_TO_L;
                        cnt_next   = dt_load;
                    end
                end
                ST_DEAD_TO_L: begin
                    if (pwm_in) begin
                        state_next = ST_HIGH;
                        cnt_next   = '0;
                    end else if (cnt == '0) begin
                        state_next = ST_LOW;
                    end else begin
                        cnt_next = cnt - DT_WIDTH'(1);
                    end
                end
                ST_LOW: begin
                    if (pwm_in) begin
                        state_next = ST_DEAD_TO_H;
                        cnt_next   = dt_load;
                    end
                end
                default: begin
                    state_next = ST_OFF;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Outputs are flopped from the next-state decode so the gates never glitch.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= ST_OFF;
            cnt           <= '0;
            pwm_h         <= 1'b0;
            pwm_l         <= 1'b0;
            dt_active     <= 1'b0;
            fault_latched <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            pwm_h         <= (state_next == ST_HIGH);
            pwm_l         <= (state_next == ST_LOW);
            dt_active     <= (state_next == ST_DEAD_TO_H) || (state_next == ST_DEAD_TO_L);
            fault_latched <= (state_next == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Self-checking bench for pwm_deadtime: directed vector table, multi-cycle corner
// sequences and randomized traffic against a cycle-count reference model.
module tb_pwm_deadtime;

    localparam int DTW  = 16;
    localparam int SYNC = 2;

    logic           clk = 1'b0;
    logic           rstn;
    logic           pwm_in;
    logic           enable;
    logic [DTW-1:0] dead_time;
    logic           fault;
    logic           fault_clr;
    logic           pwm_h;
    logic           pwm_l;
    logic           dt_active;
    logic           fault_latched;

    int total = 0;
    int bad   = 0;
    bit inv_on = 1'b0;

    pwm_deadtime #(
        .DT_WIDTH    (DTW),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .pwm_in        (pwm_in),
        .enable        (enable),
        .dead_time     (dead_time),
        .fault         (fault),
        .fault_clr     (fault_clr),
        .pwm_h         (pwm_h),
        .pwm_l         (pwm_l),
        .dt_active     (dt_active),
        .fault_latched (fault_latched)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           pwm;
        logic           en;
        logic [DTW-1:0] dt;
        logic           flt;
        logic           clr;
        logic [3:0]     exp;
    } vec_t;

    vec_t vecs[$];

    // Reference model: which gate is wanted, whether a gap is pending and how
    // many edges of that gap remain before the wanted gate may turn on.
    bit              m_fault;
    bit              m_run;
    int              m_dest;
    int              m_gap;
    logic [SYNC-1:0] m_sync;

    function void model_reset();
        m_fault = 1'b0;
        m_run   = 1'b0;
        m_dest  = 0;
        m_gap   = 0;
        m_sync  = '0;
    endfunction

    function void model_step();
        bit fs;
        int want;
        int de;
        if (!rstn) begin
            model_reset();
            return;
        end
        fs     = m_sync[SYNC-1];
        m_sync = {m_sync[SYNC-2:0], fault};
        want   = pwm_in ? 1 : 2;
        de     = (dead_time == 0) ? 1 : int'(dead_time);
        if (fs) begin
            m_fault = 1'b1;
            m_run   = 1'b0;
            m_gap   = 0;
        end else if (m_fault) begin
            if (fault_clr) m_fault = 1'b0;
        end else if (!enable) begin
            m_run = 1'b0;
            m_gap = 0;
        end else if (!m_run) begin
            m_run  = 1'b1;
            m_dest = want;
            m_gap  = de;
        end else if (m_gap > 0) begin
            if (want != m_dest) begin
                m_dest = want;
                m_gap  = 0;
            end else begin
                m_gap = m_gap - 1;
            end
        end else if (want != m_dest) begin
            m_dest = want;
            m_gap  = de;
        end
    endfunction

    function logic [3:0] model_out();
        logic h, l, d;
        h = m_run && (m_gap == 0) && (m_dest == 1);
        l = m_run && (m_gap == 0) && (m_dest == 2);
        d = m_run && (m_gap > 0);
        return {h, l, d, m_fault};
    endfunction

    function vec_t mk(logic p, logic e, int d, logic f, logic c, logic [3:0] x);
        vec_t v;
        v.pwm = p; v.en = e; v.dt = DTW'(d); v.flt = f; v.clr = c; v.exp = x;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic apply_stimulus(input vec_t v);
        pwm_in    = v.pwm;
        enable    = v.en;
        dead_time = v.dt;
        fault     = v.flt;
        fault_clr = v.clr;
    endtask

    task automatic check_output(input string name, input logic [3:0] exp);
        logic [3:0] act;
        act   = {pwm_h, pwm_l, dt_active, fault_latched};
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got h/l/dt/flt=%b expected %b", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Shoot-through guard, sampled every cycle once reset is released.
    always @(negedge clk) begin
        if (inv_on) begin
            total = total + 1;
            if (pwm_h && pwm_l) begin
                bad = bad + 1;
                $display("[TB] FAIL overlap at %0t: pwm_h=1 pwm_l=1 expected not both", $time);
            end
        end
    end

    initial begin
        int gap;
        int n;
        int fhold;
        localparam logic [3:0] OFF = 4'b0000, DT = 4'b0010, HI = 4'b1000, LO = 4'b0100, FL = 4'b0001;

        rstn = 1'b0; pwm_in = 1'b0; enable = 1'b0; dead_time = DTW'(4);
        fault = 1'b0; fault_clr = 1'b0;
        model_reset();
        repeat (3) tick();
        check_output("reset", OFF);
        rstn   = 1'b1;
        inv_on = 1'b1;

        // start-up into LOW, rise/fall with dead_time 3, swallowed pulse, zero dead time
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 1, 4, 0, 0, DT));
        vecs.push_back(mk(0, 1, 4, 0, 0, LO));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 1, 3, 0, 0, DT));
        vecs.push_back(mk(1, 1, 3, 0, 0, HI));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1, 3, 0, 0, DT));
        vecs.push_back(mk(0, 1, 3, 0, 0, LO));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 1, 5, 0, 0, DT));
        vecs.push_back(mk(0, 1, 5, 0, 0, LO));
        vecs.push_back(mk(1, 1, 0, 0, 0, DT));
        vecs.push_back(mk(1, 1, 0, 0, 0, HI));
        vecs.push_back(mk(0, 1, 0, 0, 0, DT));
        vecs.push_back(mk(0, 1, 0, 0, 0, LO));
        // fault during HIGH, ignored clears, proper release, full restart gap, enable drop
        vecs.push_back(mk(1, 1, 0, 0, 0, DT));
        vecs.push_back(mk(1, 1, 0, 0, 0, HI));
        vecs.push_back(mk(1, 1, 0, 1, 0, HI));
        vecs.push_back(mk(1, 1, 0, 1, 0, HI));
        vecs.push_back(mk(1, 1, 0, 1, 0, FL));
        vecs.push_back(mk(1, 1, 0, 1, 1, FL));
        vecs.push_back(mk(1, 1, 0, 0, 0, FL));
        vecs.push_back(mk(1, 1, 0, 0, 1, FL));
        vecs.push_back(mk(1, 1, 0, 0, 0, FL));
        vecs.push_back(mk(1, 1, 2, 0, 1, OFF));
        vecs.push_back(mk(1, 1, 2, 0, 0, DT));
        vecs.push_back(mk(1, 1, 2, 0, 0, DT));
        vecs.push_back(mk(1, 1, 2, 0, 0, HI));
        vecs.push_back(mk(1, 0, 2, 0, 0, OFF));

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
            tick();
            check_output($sformatf("vec%0d", i), vecs[i].exp);
        end

        // dead_time changed mid-gap only affects the following gap
        enable = 1'b1; pwm_in = 1'b0; dead_time = DTW'(1);
        repeat (3) tick();
        check_output("t4_low", LO);
        pwm_in = 1'b1; dead_time = DTW'(8);
        tick();
        gap = dt_active ? 1 : 0;
        dead_time = DTW'(2);
        n = 0;
        while (!pwm_h && n < 40) begin
            tick();
            n++;
            if (dt_active) gap++;
        end
        check_val("t4_rise_done", int'(n < 40), 1);
        check_val("t4_gap_rise", gap, 8);
        pwm_in = 1'b0;
        gap = 0;
        n = 0;
        while (!pwm_l && n < 40) begin
            tick();
            n++;
            if (dt_active) gap++;
        end
        check_val("t4_fall_done", int'(n < 40), 1);
        check_val("t4_gap_fall", gap, 2);

        // asynchronous reset in the middle of a dead interval
        pwm_in = 1'b1; dead_time = DTW'(10);
        repeat (2) tick();
        check_output("t6_pre", DT);
        #2;
        rstn = 1'b0;
        #1;
        check_output("t6_async_rst", OFF);
        @(negedge clk);
        rstn = 1'b1;
        model_reset();

        // randomized traffic against the reference model
        fhold = 0;
        enable = 1'b1; fault = 1'b0; fault_clr = 1'b0; dead_time = DTW'(2);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) pwm_in = ~pwm_in;
            if ($urandom_range(0, 19) == 0) dead_time = DTW'($urandom_range(0, 5));
            enable    = ($urandom_range(0, 59) != 0);
            fault_clr = ($urandom_range(0, 7) == 0);
            if (fhold > 0) begin
                fault = 1'b1;
                fhold--;
            end else begin
                fault = 1'b0;
                if ($urandom_range(0, 199) == 0) fhold = $urandom_range(1, 4);
            end
            tick();
            check_output($sformatf("rand%0d", i), model_out());
        end

        inv_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
